tick_step_gen: RTL and testbench

- Upstream enable source for the 4-bit display counter on the board.
- Divides the 50 MHz board clock into a one-cycle `tick` pulse, so the counter advances at a visible rate; `tick` connects directly to the counter's enable input.
- Also supports pause and manual single-step from a debounced push-button, so the counter/7-segment path can be stepped one value at a time.

---
 rtl/tick_step_pkg.sv | 16 +
 rtl/tick_step_gen_if.sv | 31 +++
 rtl/key_debounce.sv | 102 ++++++++++
 rtl/tick_step_gen.sv | 62 ++++++
 tb/tb_tick_step_gen.sv | 216 +++++++++++++++++++++
 5 files changed

// File: rtl/tick_step_pkg.sv
// Shared types and defaults for the tick/step enable generator.
// Imported by the key debouncer, the bus interface and the top level.
package tick_step_pkg;

    localparam int CLK_HZ           = 50000000;
    localparam int DEFAULT_DIV      = 50000000;
    localparam int DEFAULT_DEBOUNCE = 1000000;

    typedef enum logic [1:0] {
        IDLE,
        PRESS_WAIT,
        HELD,
        RELEASE_WAIT
    } db_state_t;

endpackage

// File: rtl/tick_step_gen_if.sv
// Signal bundle between the board controls and the tick/step generator.
// key_state is a debug view of the debounce FSM.
interface tick_step_gen_if;
    import tick_step_pkg::*;

    logic      run;
    logic      step_key;
    logic      tick;
    logic      key_level;
    logic      running;
    db_state_t key_state;

    modport master (
        output run,
        output step_key,
        input  tick,
        input  key_level,
        input  running,
        input  key_state
    );

    modport slave (
        input  run,
        input  step_key,
        output tick,
        output key_level,
        output running,
        output key_state
    );

endinterface

// File: rtl/key_debounce.sv
// Synchronises the raw push-button and debounces it into a clean level
// plus a one-cycle step request on each qualified press.
module key_debounce
    import tick_step_pkg::*;
#(
    parameter int DEBOUNCE_CYCLES = DEFAULT_DEBOUNCE,
    parameter bit KEY_ACTIVE_LOW  = 1'b1
) (
    input  logic      clk,
    input  logic      reset,
    input  logic      step_key,
    output logic      key_level,
    output logic      step_req,
    output db_state_t state
);

    localparam int            CW       = $clog2(DEBOUNCE_CYCLES);
    localparam logic [CW-1:0] CNT_LAST = CW'(DEBOUNCE_CYCLES - 1);

    logic          sync_1;
    logic          sync_2;
    logic          pressed;
    db_state_t     state_q;
    db_state_t     state_d;
    logic [CW-1:0] cnt_q;
    logic [CW-1:0] cnt_d;
    logic          level_q;
    logic          level_d;

    // Reset loads the released level so no phantom press appears after reset.
    always_ff @(posedge clk) begin
        if (reset) begin
            sync_1 <= KEY_ACTIVE_LOW;
            sync_2 <= KEY_ACTIVE_LOW;
        end else begin
            sync_1 <= step_key;
            sync_2 <= sync_1;
        end
    end

    assign pressed = sync_2 ^ KEY_ACTIVE_LOW;

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            level_q <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            level_q <= level_d;
        end
    end

    // step_req is decoded on the qualifying transition so it lasts exactly one cycle.
    always_comb begin
        state_d  = state_q;
        cnt_d    = cnt_q;
        level_d  = level_q;
        step_req = 1'b0;
        case (state_q)
            IDLE: begin
                if (pressed) begin
                    state_d = PRESS_WAIT;
                    cnt_d   = '0;
                end
            end
            PRESS_WAIT: begin
                if (!pressed) begin
                    state_d = IDLE;
                end else if (cnt_q == CNT_LAST) begin
                    state_d  = HELD;
                    level_d  = 1'b1;
                    step_req = 1'b1;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            HELD: begin
                if (!pressed) begin
                    state_d = RELEASE_WAIT;
                    cnt_d   = '0;
                end
            end
            RELEASE_WAIT: begin
                if (pressed) begin
                    state_d = HELD;
                end else if (cnt_q == CNT_LAST) begin
                    state_d = IDLE;
                    level_d = 1'b0;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    assign key_level = level_q;
    assign state     = state_q;

endmodule

// File: rtl/tick_step_gen.sv
// Counter enable source: free-running prescaled ticks while run is set,
// otherwise one tick per debounced press of the step key.
module tick_step_gen
    import tick_step_pkg::*;
#(
    parameter int DIV             = DEFAULT_DIV,
    parameter int DEBOUNCE_CYCLES = DEFAULT_DEBOUNCE,
    parameter bit KEY_ACTIVE_LOW  = 1'b1
) (
    input logic            clk,
    input logic            reset,
    tick_step_gen_if.slave bus
);

    localparam int            PW       = $clog2(DIV);
    localparam logic [PW-1:0] PRE_LAST = PW'(DIV - 1);

    logic          running_q;
    logic [PW-1:0] pre_cnt_q;
    logic          tick_q;
    logic          auto_tick;
    logic          step_req;
    logic          key_level;
    db_state_t     key_state;

    key_debounce #(
        .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES),
        .KEY_ACTIVE_LOW (KEY_ACTIVE_LOW)
    ) u_key_debounce (
        .clk      (clk),
        .reset    (reset),
        .step_key (bus.step_key),
        .key_level(key_level),
        .step_req (step_req),
        .state    (key_state)
    );

    assign auto_tick = running_q && (pre_cnt_q == PRE_LAST);

    // Holding the prescaler at zero while paused gives a full period after resume.
    always_ff @(posedge clk) begin
        if (reset) begin
            running_q <= 1'b0;
            pre_cnt_q <= '0;
            tick_q    <= 1'b0;
        end else begin
            running_q <= bus.run;
            if (!running_q || pre_cnt_q == PRE_LAST) begin
                pre_cnt_q <= '0;
            end else begin
                pre_cnt_q <= pre_cnt_q + 1'b1;
            end
            tick_q <= auto_tick | (step_req & ~running_q);
        end
    end

    assign bus.tick      = tick_q;
    assign bus.key_level = key_level;
    assign bus.running   = running_q;
    assign bus.key_state = key_state;

endmodule

// File: tb/tb_tick_step_gen.sv
// Bench for tick_step_gen: directed scenarios plus random run/key activity,
// every cycle compared against a behavioural model of the generator.
module tb_tick_step_gen;
    import tick_step_pkg::*;

    localparam int DIV = 4;
    localparam int DB  = 3;
    localparam bit AL  = 1'b1;

    logic clk;
    logic reset;

    tick_step_gen_if bus();

    tick_step_gen #(
        .DIV            (DIV),
        .DEBOUNCE_CYCLES(DB),
        .KEY_ACTIVE_LOW (AL)
    ) dut (
        .clk  (clk),
        .reset(reset),
        .bus  (bus)
    );

    // ---------------- clock / reset ----------------
    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // ---------------- scoreboard ----------------
    int n_cmp = 0;
    int n_err = 0;
    logic [2:0] exp_q[$];

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0d expected %0d at %0t", tag, got, exp, $time);
        end
    endtask

    // ---------------- reference model ----------------
    // The key is seen two samples late; the debounced level flips once the
    // delayed key has disagreed with it for DB+1 consecutive samples.
    // Auto ticks fall on every DIV-th cycle of an unbroken running stretch.
    logic m_tick, m_level, m_running;
    int   m_streak, m_disagree;
    logic key_dly[$];

    task automatic model_step(input bit rst, input bit run_v, input bit key_v);
        logic pressed, auto_t, step;
        if (rst) begin
            m_tick     = 1'b0;
            m_level    = 1'b0;
            m_running  = 1'b0;
            m_streak   = 0;
            m_disagree = 0;
            key_dly    = '{AL, AL};
        end else begin
            pressed = key_dly[0] ^ AL;
            auto_t  = m_running && ((m_streak % DIV) == DIV - 1);
            step    = 1'b0;
            if (pressed != m_level) begin
                m_disagree++;
                if (m_disagree == DB + 1) begin
                    m_level    = pressed;
                    m_disagree = 0;
                    step       = pressed;
                end
            end else begin
                m_disagree = 0;
            end
            m_tick    = auto_t || (step && !m_running);
            m_streak  = m_running ? m_streak + 1 : 0;
            m_running = run_v;
            void'(key_dly.pop_front());
            key_dly.push_back(key_v);
        end
        exp_q.push_back({m_tick, m_level, m_running});
    endtask

    // ---------------- driver ----------------
    int   ticks, rises, falls;
    logic prev_level;

    task automatic cycle(input bit rst, input bit run_v, input bit key_v);
        logic [2:0] e;
        reset        = rst;
        bus.run      = run_v;
        bus.step_key = key_v;
        model_step(rst, run_v, key_v);
        @(posedge clk);
        #1;
        e = exp_q.pop_front();
        check("tick", {31'b0, bus.tick}, {31'b0, e[2]});
        check("key_level", {31'b0, bus.key_level}, {31'b0, e[1]});
        check("running", {31'b0, bus.running}, {31'b0, e[0]});
        if (bus.tick) ticks++;
        if (bus.key_level && !prev_level) rises++;
        if (!bus.key_level && prev_level) falls++;
        prev_level = bus.key_level;
    endtask

    task automatic clear_counts();
        ticks = 0;
        rises = 0;
        falls = 0;
    endtask

    // ---------------- stimulus ----------------
    initial begin
        int n;
        bit run_r, key_r, rst_r;
        reset        = 1'b1;
        bus.run      = 1'b1;
        bus.step_key = 1'b1;
        prev_level   = 1'b0;
        key_dly      = '{AL, AL};
        clear_counts();

        // Reset with run and key driven active-looking: outputs must stay low.
        for (int i = 0; i < 3; i++) cycle(1, 1, 0);
        check("rst_tick", {31'b0, bus.tick}, 0);
        check("rst_key_level", {31'b0, bus.key_level}, 0);
        check("rst_running", {31'b0, bus.running}, 0);
        check("rst_state", {30'b0, bus.key_state}, {30'b0, IDLE});

        // Free run: 5 pulses in a 20-cycle window that starts on a pulse.
        n = 0;
        do begin cycle(0, 1, 1); n++; end while (!bus.tick && n < 20);
        clear_counts();
        ticks = 1;
        for (int i = 0; i < 19; i++) cycle(0, 1, 1);
        check("free_run_ticks_20", ticks, 5);

        // Pause mid-period, then resume: first tick 4 cycles after running returns.
        cycle(0, 1, 1);
        clear_counts();
        cycle(0, 0, 1);
        cycle(0, 0, 1);
        cycle(0, 1, 1);
        check("resume_running", {31'b0, bus.running}, 1);
        n = 0;
        do begin cycle(0, 1, 1); n++; end while (!bus.tick && n < 10);
        check("resume_latency", n, DIV);

        // Single step: press 10 cycles, release 10 cycles.
        for (int i = 0; i < 3; i++) cycle(0, 0, 1);
        clear_counts();
        n = 0;
        do begin cycle(0, 0, 0); n++; end while (!bus.tick && n < 15);
        check("step_latency", n, 6);
        while (n < 10) begin cycle(0, 0, 0); n++; end
        for (int i = 0; i < 10; i++) cycle(0, 0, 1);
        check("step_ticks", ticks, 1);
        check("step_rises", rises, 1);
        check("step_falls", falls, 1);

        // Two-cycle glitch is rejected.
        clear_counts();
        cycle(0, 0, 0);
        cycle(0, 0, 0);
        for (int i = 0; i < 10; i++) cycle(0, 0, 1);
        check("glitch_ticks", ticks, 0);
        check("glitch_rises", rises, 0);

        // Bounce on release still yields a single step.
        clear_counts();
        for (int i = 0; i < 8; i++) cycle(0, 0, 0);
        cycle(0, 0, 1);
        cycle(0, 0, 0);
        for (int i = 0; i < 12; i++) cycle(0, 0, 1);
        check("bounce_ticks", ticks, 1);
        check("bounce_rises", rises, 1);
        check("bounce_falls", falls, 1);

        // Key press while running: cadence untouched (6 ticks in 24 cycles).
        cycle(0, 1, 1);
        cycle(0, 1, 1);
        clear_counts();
        for (int i = 0; i < 12; i++) cycle(0, 1, 0);
        for (int i = 0; i < 12; i++) cycle(0, 1, 1);
        check("running_press_ticks", ticks, 6);
        check("running_press_rises", rises, 1);

        // Reset while the key is held, then re-qualify and step once.
        for (int i = 0; i < 3; i++) cycle(0, 0, 1);
        for (int i = 0; i < 8; i++) cycle(0, 0, 0);
        check("held_level", {31'b0, bus.key_level}, 1);
        cycle(1, 1, 0);
        cycle(1, 1, 0);
        check("midpress_rst_tick", {31'b0, bus.tick}, 0);
        check("midpress_rst_level", {31'b0, bus.key_level}, 0);
        check("midpress_rst_running", {31'b0, bus.running}, 0);
        clear_counts();
        for (int i = 0; i < 15; i++) cycle(0, 0, 0);
        check("requal_ticks", ticks, 1);
        check("requal_level", {31'b0, bus.key_level}, 1);

        // Random run/key activity with occasional resets.
        run_r = 1'b0;
        key_r = 1'b1;
        for (int i = 0; i < 600; i++) begin
            if ($urandom_range(0, 15) == 0) run_r = ~run_r;
            if ($urandom_range(0, 5) == 0) key_r = ~key_r;
            rst_r = ($urandom_range(0, 149) == 0);
            cycle(rst_r, run_r, key_r);
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
